fwvip_wb_arbiter: RTL and testbench
===================================

// Module: fwvip_wb_arbiter
// PURPOSE
//  - Shares one Wishbone (classic, non-pipelined) target between N_INIT initiators.
//  - Round-robin arbitration; grant is locked for the whole cyc tenure.
//  - Sits between the fwvip_wb initiator BFMs/RTL masters and a single wb target (b2b bench, SoC fabric).
// PARAMETERS
//  N_INIT      2    number of initiator ports (2..8)
//  ADDR_WIDTH  32   address width
//  DATA_WIDTH  32   data width; sel width = DATA_WIDTH/8
//  TIMEOUT     256  stall limit in cycles; used only when FWVIP_WB_ARB_TIMEOUT_EN is defined
// PORTS
//  clock     in   1                  single clock, rising edge
//  reset     in   1                  synchronous, active-high
//  i_cyc     in   N_INIT             per-initiator cyc
//  i_stb     in   N_INIT             per-initiator stb
//  i_we      in   N_INIT             per-initiator we
//  i_adr     in   N_INIT*ADDR_WIDTH  packed addresses; slice k = initiator k
//  i_dat_w   in   N_INIT*DATA_WIDTH  packed write data
//  i_sel     in   N_INIT*DATA_WIDTH/8  packed byte selects
//  i_dat_r   out  DATA_WIDTH         read data, broadcast to all initiators
//  i_ack     out  N_INIT             ack, routed to granted initiator only
//  i_err     out  N_INIT             err, routed to granted initiator only
//  t_cyc/t_stb/t_we  out 1           target control
//  t_adr/t_dat_w/t_sel  out          target address, write data, byte selects
//  t_dat_r   in   DATA_WIDTH         target read data
//  t_ack/t_err  in 1                 target response
//  gnt       out  N_INIT             one-hot grant vector (debug/coverage)
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, t_cyc=t_stb=t_we=0, t_adr/t_dat_w/t_sel=0, i_ack=i_err=0,
//    i_dat_r=0; last-winner pointer=N_INIT-1, so initiator 0 has first priority.
//  - IDLE: if any i_cyc is set, the round-robin picker selects the first requester after the last winner;
//    gnt registered; -> GRANT next cycle. Cyc-to-t_cyc latency = 1 cycle.
//  - GRANT(g): t_* = initiator g's signals (combinational mux of registered index); t_cyc=i_cyc[g].
//    i_ack[g]=t_ack, i_err[g]=t_err; all other acks/errs are 0; i_dat_r=t_dat_r.
//  - i_cyc[g] low in GRANT: t_cyc drops in the same cycle; -> IDLE; pointer=g. There is always
//    >=1 IDLE cycle between tenures.
//  - Requests arriving simultaneously in IDLE are resolved by the picker in a single cycle.
//  - A non-granted initiator sees only ack=err=0; it must hold its request (standard wb).
//  - Reset mid-tenure: immediate return to reset values; the target sees t_cyc low next edge.
// CONFIGURATION
//  FWVIP_WB_ARB_TIMEOUT_EN defined: a $clog2(TIMEOUT+1)-bit counter increments while
//    t_stb & ~t_ack & ~t_err. Counter cleared on ack/err/stb low.
//    When the counter reaches TIMEOUT: i_err[g]=1 for 1 cycle, t_cyc/t_stb forced 0
//    -> DRAIN. DRAIN holds until i_cyc[g]=0, then -> IDLE.
//  Macro undefined: no counter, no DRAIN state; a stalled target blocks the arbiter indefinitely.
// STRUCTURE
//  - fwvip_wb_arb_pkg: state enum {IDLE,GRANT,DRAIN}, constants, and rr_next() helper function.
//  - Sub-module fwvip_wb_arb_rr: combinational round-robin picker
//    (req[N], last_idx -> gnt one-hot + idx).
// TESTING
//  - Single initiator 1 write adr=0x10 dat=0xA5A5 -> t_cyc 1 cycle after i_cyc, ack only on i_ack[1].
//  - i_cyc[0] and i_cyc[1] raised together after reset -> initiator 0 granted first, 1 after 1 IDLE cycle.
//  - Both initiators request continuously for 4 tenures -> grants alternate 0,1,0,1.
//  - Initiator 0 burst of 3 reads under one cyc -> grant held; initiator 1 not granted until cyc drops.
//  - Reset asserted mid-read -> all outputs 0 next edge; first grant after reset goes to initiator 0.
//  - TIMEOUT_EN, TIMEOUT=16, target never acks -> i_err[g] pulses on stall cycle 16, then DRAIN->IDLE.

Source files
------------

// File: rtl/fwvip_wb_arb_pkg.sv
// rtl/fwvip_wb_arb_pkg.sv - state type, limits and round-robin helper for fwvip_wb_arbiter
package fwvip_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int MAX_INIT  = 8;
  localparam int MAX_IDX_W = 3;

  // First requester strictly after 'last' (wrapping over n ports); 'last' itself has lowest
  // priority. With no requester at all the result is 'last' and the caller ignores it.
  function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_INIT-1:0]  req,
                                                   input logic [MAX_IDX_W-1:0] last,
                                                   input int                   n);
    logic [MAX_IDX_W-1:0] res;
    logic [MAX_IDX_W-1:0] k3;
    int                   k;
    res = last;
    // Walk from the farthest offset down so the nearest requester overwrites last.
    for (int i = MAX_INIT; i >= 1; i--) begin
      if (i <= n) begin
        k  = (int'(last) + i) % n;
        k3 = MAX_IDX_W'(k);
        if (req[k3]) res = k3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fwvip_wb_arb_rr.sv
// rtl/fwvip_wb_arb_rr.sv - combinational round-robin picker (req, last index -> one-hot + index)
module fwvip_wb_arb_rr
  import fwvip_wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  gnt
);

  logic [MAX_INIT-1:0]  req_ext;
  logic [MAX_IDX_W-1:0] last_ext;
  logic [MAX_IDX_W-1:0] pick;

  assign req_ext  = MAX_INIT'(req);
  assign last_ext = MAX_IDX_W'(last_idx);
  assign pick     = rr_next(req_ext, last_ext, N);

  assign valid = |req;
  assign idx   = IW'(pick);
  assign gnt   = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/fwvip_wb_arbiter.sv
// rtl/fwvip_wb_arbiter.sv - round-robin N:1 classic Wishbone arbiter; optional stall timeout via FWVIP_WB_ARB_TIMEOUT_EN
module fwvip_wb_arbiter
  import fwvip_wb_arb_pkg::*;
#(
  parameter int N_INIT     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_INIT-1:0]                i_cyc,
  input  logic [N_INIT-1:0]                i_stb,
  input  logic [N_INIT-1:0]                i_we,
  input  logic [N_INIT*ADDR_WIDTH-1:0]     i_adr,
  input  logic [N_INIT*DATA_WIDTH-1:0]     i_dat_w,
  input  logic [N_INIT*DATA_WIDTH/8-1:0]   i_sel,
  output logic [DATA_WIDTH-1:0]            i_dat_r,
  output logic [N_INIT-1:0]                i_ack,
  output logic [N_INIT-1:0]                i_err,
  output logic                             t_cyc,
  output logic                             t_stb,
  output logic                             t_we,
  output logic [ADDR_WIDTH-1:0]            t_adr,
  output logic [DATA_WIDTH-1:0]            t_dat_w,
  output logic [DATA_WIDTH/8-1:0]          t_sel,
  input  logic [DATA_WIDTH-1:0]            t_dat_r,
  input  logic                             t_ack,
  input  logic                             t_err,
  output logic [N_INIT-1:0]                gnt
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(N_INIT);

  if (N_INIT < 2 || N_INIT > MAX_INIT || TIMEOUT < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_err
    $error("fwvip_wb_arbiter: unsupported parameter set");
  end

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_INIT-1:0]  gnt_q, gnt_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [N_INIT-1:0]  pick_gnt;

`ifdef FWVIP_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               stall;
`endif

  // Per-initiator views of the packed buses so the mux below indexes plain arrays.
  logic [ADDR_WIDTH-1:0] adr_a [N_INIT];
  logic [DATA_WIDTH-1:0] dat_a [N_INIT];
  logic [SW-1:0]         sel_a [N_INIT];

  for (genvar k = 0; k < N_INIT; k++) begin : g_unpack
    assign adr_a[k] = i_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[k] = i_dat_w[k*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[k] = i_sel[k*SW +: SW];
  end

  // idx_q doubles as the last-winner pointer: it only changes when a new tenure is granted.
  fwvip_wb_arb_rr #(
    .N  (N_INIT),
    .IW (IW)
  ) u_rr (
    .req      (i_cyc),
    .last_idx (idx_q),
    .valid    (pick_valid),
    .idx      (pick_idx),
    .gnt      (pick_gnt)
  );

  assign gnt = gnt_q;

  // State, granted index and grant vector registers; pointer resets so initiator 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= IW'(N_INIT - 1);
      gnt_q   <= '0;
`ifdef FWVIP_WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
`ifdef FWVIP_WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic and the combinational initiator/target mux for the granted index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    t_we    = 1'b0;
    t_adr   = '0;
    t_dat_w = '0;
    t_sel   = '0;
    i_ack   = '0;
    i_err   = '0;
    i_dat_r = '0;
`ifdef FWVIP_WB_ARB_TIMEOUT_EN
    cnt_d   = '0;
    stall   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          gnt_d   = pick_gnt;
        end
      end
      GRANT: begin
        // Dropping cyc ends the tenure immediately; the target never sees the idle cycle as cyc.
        if (!i_cyc[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          t_cyc          = 1'b1;
          t_stb          = i_stb[idx_q];
          t_we           = i_we[idx_q];
          t_adr          = adr_a[idx_q];
          t_dat_w        = dat_a[idx_q];
          t_sel          = sel_a[idx_q];
          i_dat_r        = t_dat_r;
          i_ack[idx_q]   = t_ack;
          i_err[idx_q]   = t_err;
`ifdef FWVIP_WB_ARB_TIMEOUT_EN
          stall = i_stb[idx_q] & ~t_ack & ~t_err;
          if (stall) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
              i_err[idx_q] = 1'b1;
              t_cyc        = 1'b0;
              t_stb        = 1'b0;
              state_d      = DRAIN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`endif
        end
      end
`ifdef FWVIP_WB_ARB_TIMEOUT_EN
      DRAIN: begin
        // Target already released; wait for the timed-out initiator to give up its cycle.
        if (!i_cyc[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fwvip_wb_arbiter.sv
// tb/tb_fwvip_wb_arbiter.sv - scoreboard bench for fwvip_wb_arbiter with random initiators and target
module tb_fwvip_wb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    i_cyc = '0, i_stb = '0, i_we = '0;
  logic [N*AW-1:0] i_adr = '0;
  logic [N*DW-1:0] i_dat_w = '0;
  logic [N*SW-1:0] i_sel = '0;
  logic [DW-1:0]   i_dat_r;
  logic [N-1:0]    i_ack, i_err, gnt;
  logic            t_cyc, t_stb, t_we;
  logic [AW-1:0]   t_adr;
  logic [DW-1:0]   t_dat_w;
  logic [SW-1:0]   t_sel;
  logic [DW-1:0]   t_dat_r = '0;
  logic            t_ack = 1'b0, t_err = 1'b0;

  fwvip_wb_arbiter #(.N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
    .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel),
    .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err), .gnt(gnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } beat_t;

  beat_t exp_q [N][$];
  int    checks = 0;
  int    failures = 0;
  bit    tgt_stall = 1'b0;
  int    wait_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Target: acks after 0..2 random wait cycles unless stalled; read data derived from address.
  initial begin
    forever begin
      @(posedge clock); #2;
      if (t_cyc && t_stb && !tgt_stall) begin
        if (wait_left == 0) begin
          t_ack = 1'b1;
          t_dat_r = rd_val(t_adr);
          wait_left = $urandom_range(0, 2);
        end else begin
          t_ack = 1'b0;
          wait_left--;
        end
      end else begin
        t_ack = 1'b0;
      end
    end
  end

  // Monitor: round-robin reference on every tenure start, scoreboard pop on every target handshake.
  int          last_w = N - 1;
  int          owner = -1;
  int          ew;
  logic        prev_tcyc = 1'b0;
  logic [N-1:0] prev_req = '0;
  beat_t       mb;

  always @(negedge clock) begin
    if (reset) begin
      last_w = N - 1;
      owner = -1;
      prev_tcyc = 1'b0;
      prev_req = '0;
    end else begin
      if (t_cyc && !prev_tcyc) begin
        ew = -1;
        for (int i = N; i >= 1; i--) if (prev_req[(last_w + i) % N]) ew = (last_w + i) % N;
        if (ew < 0) begin
          checks++; failures++;
          $display("FAIL rr_start actual=tenure_started required=no_tenure (no request pending)");
          owner = -1;
        end else begin
          check("rr_grant", 64'(gnt), 64'(1 << ew));
          owner = ew;
          last_w = ew;
        end
      end
      if (!t_cyc) owner = -1;
      if (t_cyc && t_stb && t_ack) begin
        if (owner < 0 || exp_q[owner].size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected actual=adr_0x%0h required=no_transfer", t_adr);
        end else begin
          mb = exp_q[owner].pop_front();
          check("beat_ctrl", 64'({t_we, t_sel, t_adr}), 64'({mb.we, mb.sel, mb.adr}));
          if (mb.we) check("beat_wdata", 64'(t_dat_w), 64'(mb.dat));
          check("ack_route", 64'(i_ack), 64'(1 << owner));
        end
      end
      prev_tcyc = t_cyc;
      prev_req = i_cyc;
    end
  end

  task automatic do_tenure(input int k, input int nbeats, input bit fixed,
                           input logic [AW-1:0] fadr, input logic [DW-1:0] fdat, input bit fwe);
    int n;
    @(posedge clock); #1;
    i_cyc[k] = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      beat_t bt;
      bt.adr = fixed ? fadr : AW'($urandom);
      bt.we  = fixed ? fwe : 1'($urandom_range(0, 1));
      bt.dat = fixed ? fdat : DW'($urandom);
      bt.sel = fixed ? '1 : SW'($urandom_range(1, 15));
      i_stb[k] = 1'b1;
      i_we[k] = bt.we;
      i_adr[k*AW +: AW] = bt.adr;
      i_dat_w[k*DW +: DW] = bt.dat;
      i_sel[k*SW +: SW] = bt.sel;
      exp_q[k].push_back(bt);
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!i_ack[k] && n < 400);
      if (!i_ack[k]) begin
        checks++; failures++;
        $display("FAIL ack_timeout actual=no_ack required=ack initiator=%0d", k);
      end else if (!bt.we) begin
        check("rd_data", 64'(i_dat_r), 64'(rd_val(bt.adr)));
      end
      @(posedge clock); #1;
    end
    i_stb[k] = 1'b0;
    i_cyc[k] = 1'b0;
  endtask

  task automatic apply_reset(input bit clear);
    @(posedge clock); #1;
    reset = 1'b1;
    if (clear) begin
      i_cyc = '0; i_stb = '0; i_we = '0; i_adr = '0; i_dat_w = '0; i_sel = '0;
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_tctl", 64'({t_cyc, t_stb, t_we}), 64'd0);
    check("rst_tadr", 64'(t_adr), 64'd0);
    check("rst_twdat", 64'({t_dat_w, t_sel}), 64'd0);
    check("rst_iresp", 64'({i_ack, i_err, gnt}), 64'd0);
    check("rst_idatr", 64'(i_dat_r), 64'd0);
    for (int k = 0; k < N; k++) exp_q[k].delete();
    i_cyc = '0; i_stb = '0; i_we = '0; i_adr = '0; i_dat_w = '0; i_sel = '0;
    tgt_stall = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    apply_reset(1'b1);

    // Single write from initiator 1; t_cyc must follow i_cyc by exactly one cycle.
    fork
      do_tenure(1, 1, 1'b1, 32'h10, 32'hA5A5, 1'b1);
      begin
        n = 0;
        do begin @(negedge clock); n++; end while (!i_cyc[1] && n < 10);
        check("lat_same_cycle", 64'(t_cyc), 64'd0);
        @(negedge clock);
        check("lat_next_cycle", 64'({t_cyc, gnt}), 64'({1'b1, 2'b10}));
      end
    join

    // Simultaneous requests straight after reset: 0 then 1.
    apply_reset(1'b1);
    fork
      do_tenure(0, 1, 1'b0, '0, '0, 1'b0);
      do_tenure(1, 1, 1'b0, '0, '0, 1'b0);
    join

    // Continuous demand from both: grants alternate.
    fork
      begin do_tenure(0, 1, 1'b0, '0, '0, 1'b0); do_tenure(0, 1, 1'b0, '0, '0, 1'b0); end
      begin do_tenure(1, 1, 1'b0, '0, '0, 1'b0); do_tenure(1, 1, 1'b0, '0, '0, 1'b0); end
    join

    // Three-read burst under one cyc holds the grant against a waiting initiator 1.
    fork
      do_tenure(0, 3, 1'b1, 32'h100, '0, 1'b0);
      begin @(posedge clock); do_tenure(1, 1, 1'b0, '0, '0, 1'b0); end
    join

    // Reset in the middle of a stalled read, then both request: 0 must win.
    tgt_stall = 1'b1;
    @(posedge clock); #1;
    i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_we[0] = 1'b0; i_adr[0 +: AW] = 32'h200;
    @(negedge clock);
    @(negedge clock);
    check("midread_active", 64'({t_cyc, t_stb, t_adr}), 64'({1'b1, 1'b1, 32'h200}));
    apply_reset(1'b0);
    fork
      do_tenure(0, 1, 1'b0, '0, '0, 1'b0);
      do_tenure(1, 1, 1'b0, '0, '0, 1'b0);
    join

`ifdef FWVIP_WB_ARB_TIMEOUT_EN
    // Target never acks: error pulse on the 16th stall cycle, then drain until cyc drops.
    apply_reset(1'b1);
    tgt_stall = 1'b1;
    @(posedge clock); #1;
    i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_adr[0 +: AW] = 32'h300;
    n = 0;
    do begin @(negedge clock); n++; end while (!t_cyc && n < 10);
    n = 1;
    while (!i_err[0] && n < 40) begin @(negedge clock); n++; end
    check("timeout_cycle", 64'(n), 64'(TO));
    check("timeout_err_cycle", 64'({i_err, t_cyc, t_stb}), 64'({2'b01, 1'b0, 1'b0}));
    @(negedge clock);
    check("drain_err_pulse", 64'({i_err, t_cyc}), 64'd0);
    @(negedge clock);
    check("drain_hold", 64'({t_cyc, gnt}), 64'({1'b0, 2'b01}));
    @(posedge clock); #1;
    i_cyc[0] = 1'b0; i_stb[0] = 1'b0;
    tgt_stall = 1'b0;
    do_tenure(1, 1, 1'b0, '0, '0, 1'b0);
`endif

    // Random traffic from both initiators.
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          do_tenure(0, $urandom_range(1, 3), 1'b0, '0, '0, 1'b0);
        end
      end
      begin
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          do_tenure(1, $urandom_range(1, 3), 1'b0, '0, '0, 1'b0);
        end
      end
    join

    repeat (3) @(negedge clock);
    for (int k = 0; k < N; k++) check("queue_drained", 64'(exp_q[k].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
